// File: rtl/booth_op_sequencer_pkg.sv
// Shared op-state encodings and width default for the Booth sequencer and its
// result controller.
package booth_op_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [1:0] OP_IDLE        = 2'b00;
    localparam logic [1:0] OP_CALCULATING = 2'b01;
    localparam logic [1:0] OP_DONE        = 2'b10;

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: a three-bit window of the multiplier selects 0, +-M or +-2M.
// The result is two bits wider than M so that -2 * (-2^(WIDTH-1)) cannot wrap.
module booth_digit_encoder
    import booth_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       recodeBits,
    input  logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH+1:0] partialProduct
);

    logic [WIDTH+1:0] mExt;
    logic [WIDTH+1:0] mTwice;

    assign mExt   = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    assign mTwice = {mExt[WIDTH:0], 1'b0};

    always_comb begin
        partialProduct = '0;
        case (recodeBits)
            3'b001, 3'b010: partialProduct = mExt;
            3'b011:         partialProduct = mTwice;
            3'b100:         partialProduct = -mTwice;
            3'b101, 3'b110: partialProduct = -mExt;
            default:        partialProduct = '0;
        endcase
    end

endmodule

// File: rtl/booth_op_sequencer.sv
// Issues one aligned radix-4 Booth partial product per cycle to the accumulating
// result controller, framed by a clear pulse before and a done pulse after.
module booth_op_sequencer
    import booth_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [1:0]         op,
    output logic [2*WIDTH-1:0] shiftedNumber,
    output logic               clearResult,
    output logic               done
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    logic [CW-1:0]    stepCount;
    logic [WIDTH-1:0] mReg;
    logic [WIDTH:0]   recode;
    logic [WIDTH+1:0] partialProduct;
    logic [WIDTH:0]   recodeNext;

    booth_digit_encoder #(.WIDTH(WIDTH)) encoder (
        .recodeBits    (recode[2:0]),
        .multiplicand  (mReg),
        .partialProduct(partialProduct)
    );

    assign recodeNext = {{2{recode[WIDTH]}}, recode[WIDTH:2]};

    // A high clearResult while IDLE marks the accept cycle: the consumer zeroes its
    // register now, and step 0 is issued on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            op            <= OP_IDLE;
            shiftedNumber <= '0;
            clearResult   <= 1'b0;
            done          <= 1'b0;
            stepCount     <= '0;
            mReg          <= '0;
            recode        <= '0;
        end else begin
            clearResult <= 1'b0;
            done        <= 1'b0;
            case (op)
                OP_IDLE: begin
                    if (clearResult) begin
                        op            <= OP_CALCULATING;
                        shiftedNumber <= {partialProduct, {(WIDTH-2){1'b0}}};
                        recode        <= recodeNext;
                        stepCount     <= '0;
                    end else if (start) begin
                        mReg        <= multiplicand;
                        recode      <= {multiplier, 1'b0};
                        clearResult <= 1'b1;
                    end
                end
                OP_CALCULATING: begin
                    if (stepCount == LAST_STEP) begin
                        op            <= OP_DONE;
                        shiftedNumber <= '0;
                        done          <= 1'b1;
                    end else begin
                        shiftedNumber <= {partialProduct, {(WIDTH-2){1'b0}}};
                        recode        <= recodeNext;
                        stepCount     <= stepCount + CW'(1);
                    end
                end
                OP_DONE: begin
                    op        <= OP_IDLE;
                    stepCount <= '0;
                end
                default: op <= OP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Bench: sequencer plus a result-controller model, products checked against M*Q
// through a scoreboard of expected products.
module tb_booth_op_sequencer;
    import booth_op_sequencer_pkg::*;

    localparam int WIDTH = 64;
    localparam int STEPS = WIDTH / 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [1:0]         op;
    logic [2*WIDTH-1:0] shiftedNumber;
    logic               clearResult;
    logic               done;

    logic signed [2*WIDTH-1:0] result;
    logic signed [2*WIDTH-1:0] resultAsr;

    logic [2*WIDTH-1:0] expectedQ[$];
    int assertCount = 0;
    int failCount   = 0;
    int calcRun     = 0;
    int doneCount   = 0;
    int clearCount  = 0;
    int acceptCount = 0;
    logic prevClear = 1'b0;
    logic prevDone  = 1'b0;

    always #5 clk = ~clk;

    booth_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op           (op),
        .shiftedNumber(shiftedNumber),
        .clearResult  (clearResult),
        .done         (done)
    );

    // Result controller: zero on clear, accumulate pp + (result ASR 2) while calculating
    assign resultAsr = result >>> 2;

    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else if (clearResult)
            result <= '0;
        else if (op == OP_CALCULATING)
            result <= shiftedNumber + resultAsr;
    end

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        logic signed [2*WIDTH-1:0] a;
        logic signed [2*WIDTH-1:0] b;
        a = {{WIDTH{m[WIDTH-1]}}, m};
        b = {{WIDTH{q[WIDTH-1]}}, q};
        return a * b;
    endfunction

    task automatic checkOutput(input string tag, input logic [2*WIDTH-1:0] observed,
                               input logic [2*WIDTH-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q, input bit hold);
        bit found;
        found        = 1'b0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (clearResult) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("accept", {127'd0, found}, 128'd1);
        if (found) begin
            expectedQ.push_back(model(m, q));
            acceptCount++;
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (expectedQ.size() == 0 && op == OP_IDLE) begin
                idle = 1'b1;
                break;
            end
        end
        checkOutput("drain", {127'd0, idle}, 128'd1);
    endtask

    // Protocol monitor: pulse widths, phase sequencing, step count and product scoreboard
    always @(negedge clk) begin
        if (reset) begin
            calcRun   = 0;
            prevClear = 1'b0;
            prevDone  = 1'b0;
        end else begin
            checkOutput("opLegal", {127'd0, (op == 2'b11)}, 128'd0);
            if (prevClear) begin
                checkOutput("clearPulseWidth", {127'd0, clearResult}, 128'd0);
                checkOutput("opAfterClear", {126'd0, op}, {126'd0, OP_CALCULATING});
            end
            if (prevDone) begin
                checkOutput("donePulseWidth", {127'd0, done}, 128'd0);
                checkOutput("opAfterDone", {126'd0, op}, {126'd0, OP_IDLE});
            end
            if (clearResult) clearCount++;
            if (op == OP_CALCULATING) calcRun++;
            if (done) begin
                checkOutput("doneOp", {126'd0, op}, {126'd0, OP_DONE});
                checkOutput("doneShifted", shiftedNumber, 128'd0);
                checkOutput("calcCycles", 128'(calcRun), 128'(STEPS));
                calcRun = 0;
                doneCount++;
                checkOutput("scoreboardDepth", {127'd0, (expectedQ.size() > 0)}, 128'd1);
                if (expectedQ.size() > 0)
                    checkOutput("product", result, expectedQ.pop_front());
            end
            prevClear = clearResult;
            prevDone  = done;
        end
    end

    initial begin
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] q;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetOp", {126'd0, op}, 128'd0);
        checkOutput("resetShifted", shiftedNumber, 128'd0);
        checkOutput("resetClear", {127'd0, clearResult}, 128'd0);
        checkOutput("resetDone", {127'd0, done}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(64'd3, 64'd5, 1'b0);
        waitIdle();
        applyStimulus(-64'sd7, 64'd6, 1'b0);
        waitIdle();
        applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        waitIdle();
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
        waitIdle();

        // A start pulse in the middle of an operation must not disturb it
        applyStimulus(64'd123, -64'sd45, 1'b0);
        repeat (11) @(negedge clk);
        multiplicand = 64'd999;
        multiplier   = 64'd888;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("ignoredStartIdle", {126'd0, op}, {126'd0, OP_IDLE});

        // Reset during step 17 aborts the operation
        applyStimulus(64'd99, 64'd77, 1'b0);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetOp", {126'd0, op}, 128'd0);
        checkOutput("midResetShifted", shiftedNumber, 128'd0);
        checkOutput("midResetDone", {127'd0, done}, 128'd0);
        expectedQ.delete();
        acceptCount--;
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(64'd2, 64'd2, 1'b0);
        waitIdle();

        // Start held high: three directed then random operations back-to-back
        applyStimulus(64'd11, -64'sd13, 1'b1);
        applyStimulus(-64'sd1, -64'sd1, 1'b1);
        applyStimulus(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            m = {$urandom(), $urandom()};
            q = {$urandom(), $urandom()};
            if (i % 97 == 0) m = 64'h8000_0000_0000_0000;
            applyStimulus(m, q, 1'b1);
        end
        start = 1'b0;
        waitIdle();

        checkOutput("doneCount", 128'(doneCount), 128'(acceptCount));
        checkOutput("clearCount", 128'(clearCount), 128'(acceptCount + 1));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
